// File: rtl/cpu_pkg.sv
// cpu_pkg: shared definitions for the fetch/decode slice of the CPU.
//   - opcode constants (instr[15:12])
//   - instruction field positions
//   - fetch FSM state encoding
//   - branch condition constants (instr[11:9])
package cpu_pkg;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h2;
  localparam logic [3:0] OP_OR   = 4'h3;
  localparam logic [3:0] OP_XOR  = 4'h4;
  localparam logic [3:0] OP_SHL  = 4'h5;
  localparam logic [3:0] OP_SHR  = 4'h6;
  localparam logic [3:0] OP_ADDI = 4'h7;
  localparam logic [3:0] OP_LD   = 4'h8;
  localparam logic [3:0] OP_ST   = 4'h9;
  localparam logic [3:0] OP_LUI  = 4'hA;
  localparam logic [3:0] OP_BR   = 4'hB;
  localparam logic [3:0] OP_JAL  = 4'hC;
  localparam logic [3:0] OP_JR   = 4'hD;
  localparam logic [3:0] OP_NOP  = 4'hE;
  localparam logic [3:0] OP_EXEC = 4'hF;

  localparam int OPC_MSB  = 15;
  localparam int OPC_LSB  = 12;
  localparam int COND_MSB = 11;
  localparam int COND_LSB = 9;

  typedef enum logic [1:0] {
    ISSUE = 2'd0,
    WAIT  = 2'd1,
    HOLD  = 2'd2
  } fetch_state_t;

  localparam logic [2:0] COND_EQ   = 3'b000;
  localparam logic [2:0] COND_NE   = 3'b001;
  localparam logic [2:0] COND_LT   = 3'b010;
  localparam logic [2:0] COND_GE   = 3'b011;
  localparam logic [2:0] COND_LTU  = 3'b100;
  localparam logic [2:0] COND_GEU  = 3'b101;
  localparam logic [2:0] COND_NEV  = 3'b110;
  localparam logic [2:0] COND_TRUE = 3'b111;

endpackage

// File: rtl/if_hold_reg.sv
// if_hold_reg: one-entry buffer for a fetched instruction and its address.
// Catches a memory response that arrives while decode still holds the
// previous instruction, so memory never has to be back-pressured.
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   i_wr           load i_instr/i_pc, mark full
//   i_instr, i_pc  data to store
//   i_rd           entry consumed, mark empty
//   i_clr          flush (redirect), wins over i_wr
//   o_full         entry valid
//   o_instr, o_pc  stored data
module if_hold_reg #(
  parameter int ADDR_W  = 16,
  parameter int INSTR_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_wr,
  input  logic [INSTR_W-1:0] i_instr,
  input  logic [ADDR_W-1:0]  i_pc,
  input  logic               i_rd,
  input  logic               i_clr,
  output logic               o_full,
  output logic [INSTR_W-1:0] o_instr,
  output logic [ADDR_W-1:0]  o_pc
);

  logic               r_full;
  logic [INSTR_W-1:0] r_instr;
  logic [ADDR_W-1:0]  r_pc;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_full  <= 1'b0;
      r_instr <= '0;
      r_pc    <= '0;
    end else if (i_clr) begin
      r_full <= 1'b0;
    end else if (i_wr) begin
      r_full  <= 1'b1;
      r_instr <= i_instr;
      r_pc    <= i_pc;
    end else if (i_rd) begin
      r_full <= 1'b0;
    end
  end

  assign o_full  = r_full;
  assign o_instr = r_instr;
  assign o_pc    = r_pc;

endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: owns the PC, fetches 16-bit instructions and presents
// them to decode with their PC and PC+1 (JAL link value).
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   imem_req/imem_addr       fetch request, accepted by memory same cycle
//   imem_rvalid/imem_rdata   response, >=1 cycle after the request
//   stall                    decode not accepting this cycle
//   redirect/redirect_pc     control-flow change, overrides stall
//   if_valid/if_instr        instruction presented to decode
//   if_opcode/if_cond        field slices of if_instr
//   if_pc/if_pc_plus1        address of if_instr and its successor
//   dbg_state                current fetch FSM state
//
// Handshakes: memory takes a request in every cycle imem_req=1 (no ready);
// exactly one response strobe imem_rvalid follows each request, and only
// one request is ever outstanding. Toward decode, the instruction moves on
// in a cycle where if_valid=1 and stall=0; while if_valid=1 and stall=1 all
// if_* outputs hold.
module instr_fetch_unit
  import cpu_pkg::*;
#(
  parameter int                ADDR_W   = 16,
  parameter int                INSTR_W  = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = 16'h0000
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_rvalid,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               stall,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               if_valid,
  output logic [INSTR_W-1:0] if_instr,
  output logic [3:0]         if_opcode,
  output logic [2:0]         if_cond,
  output logic [ADDR_W-1:0]  if_pc,
  output logic [ADDR_W-1:0]  if_pc_plus1,
  output logic [1:0]         dbg_state
);

  localparam logic [ADDR_W-1:0] PC_ONE = 1;

  fetch_state_t       r_state;
  logic [ADDR_W-1:0]  r_pc;
  logic               r_kill;      // outstanding response belongs to a dead path
  logic               r_valid;
  logic [INSTR_W-1:0] r_instr;
  logic [ADDR_W-1:0]  r_out_pc;
  logic [ADDR_W-1:0]  r_out_pc_plus1;

  logic               w_consume;
  logic               w_hold_wr;
  logic               w_hold_rd;
  logic               w_hold_full;
  logic [INSTR_W-1:0] w_hold_instr;
  logic [ADDR_W-1:0]  w_hold_pc;

  assign w_consume = r_valid && !stall;

  // A good response with the output still occupied goes to the hold entry.
  assign w_hold_wr = (r_state == WAIT) && imem_rvalid && !r_kill && !redirect &&
                     r_valid && !w_consume;
  assign w_hold_rd = (r_state == HOLD) && w_consume && !redirect;

  if_hold_reg #(
    .ADDR_W  (ADDR_W),
    .INSTR_W (INSTR_W)
  ) u_hold (
    .clk     (clk),
    .rst     (rst),
    .i_wr    (w_hold_wr),
    .i_instr (imem_rdata),
    .i_pc    (r_pc),
    .i_rd    (w_hold_rd),
    .i_clr   (redirect),
    .o_full  (w_hold_full),
    .o_instr (w_hold_instr),
    .o_pc    (w_hold_pc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= ISSUE;
      r_pc           <= RESET_PC;
      r_kill         <= 1'b0;
      r_valid        <= 1'b0;
      r_instr        <= '0;
      r_out_pc       <= '0;
      r_out_pc_plus1 <= '0;
    end else if (redirect) begin
      r_pc    <= redirect_pc;
      r_valid <= 1'b0;
      case (r_state)
        // The request issued this cycle, or one still in flight, is stale.
        ISSUE: begin
          r_kill  <= 1'b1;
          r_state <= WAIT;
        end
        WAIT: begin
          if (imem_rvalid) begin
            r_kill  <= 1'b0;
            r_state <= ISSUE;
          end else begin
            r_kill  <= 1'b1;
            r_state <= WAIT;
          end
        end
        default: begin
          r_kill  <= 1'b0;
          r_state <= ISSUE;
        end
      endcase
    end else begin
      if (w_consume) r_valid <= 1'b0;
      case (r_state)
        ISSUE: r_state <= WAIT;
        WAIT: begin
          if (imem_rvalid) begin
            if (r_kill) begin
              r_kill  <= 1'b0;
              r_state <= ISSUE;
            end else if (!r_valid || w_consume) begin
              r_valid        <= 1'b1;
              r_instr        <= imem_rdata;
              r_out_pc       <= r_pc;
              r_out_pc_plus1 <= r_pc + PC_ONE;
              r_pc           <= r_pc + PC_ONE;
              r_state        <= ISSUE;
            end else begin
              r_pc    <= r_pc + PC_ONE;
              r_state <= HOLD;
            end
          end
        end
        HOLD: begin
          if (w_consume && w_hold_full) begin
            r_valid        <= 1'b1;
            r_instr        <= w_hold_instr;
            r_out_pc       <= w_hold_pc;
            r_out_pc_plus1 <= w_hold_pc + PC_ONE;
            r_state        <= ISSUE;
          end
        end
        default: r_state <= ISSUE;
      endcase
    end
  end

  assign imem_req    = (r_state == ISSUE) && !rst;
  assign imem_addr   = r_pc;
  assign if_valid    = r_valid;
  assign if_instr    = r_instr;
  assign if_opcode   = r_instr[OPC_MSB:OPC_LSB];
  assign if_cond     = r_instr[COND_MSB:COND_LSB];
  assign if_pc       = r_out_pc;
  assign if_pc_plus1 = r_out_pc_plus1;
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;
  import cpu_pkg::*;

  logic clk;
  logic rst;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT A: RESET_PC = 0, variable memory latency ----------
  logic        req_a, rvalid_a;
  logic [15:0] addr_a, rdata_a, rpc_a;
  logic        stall_a, redir_a;
  logic        valid_a;
  logic [15:0] instr_a, pc_a, p1_a;
  logic [3:0]  opc_a;
  logic [2:0]  cond_a;
  logic [1:0]  st_a;

  instr_fetch_unit #(.ADDR_W(16), .INSTR_W(16), .RESET_PC(16'h0000)) dut_a (
    .clk(clk), .rst(rst),
    .imem_req(req_a), .imem_addr(addr_a),
    .imem_rvalid(rvalid_a), .imem_rdata(rdata_a),
    .stall(stall_a), .redirect(redir_a), .redirect_pc(rpc_a),
    .if_valid(valid_a), .if_instr(instr_a), .if_opcode(opc_a), .if_cond(cond_a),
    .if_pc(pc_a), .if_pc_plus1(p1_a), .dbg_state(st_a)
  );

  // ---------------- DUT B: RESET_PC = FFFF, 1-cycle memory ----------------
  logic        req_b, rvalid_b;
  logic [15:0] addr_b, rdata_b, rpc_b;
  logic        stall_b, redir_b;
  logic        valid_b;
  logic [15:0] instr_b, pc_b, p1_b;
  logic [3:0]  opc_b;
  logic [2:0]  cond_b;
  logic [1:0]  st_b;

  instr_fetch_unit #(.ADDR_W(16), .INSTR_W(16), .RESET_PC(16'hFFFF)) dut_b (
    .clk(clk), .rst(rst),
    .imem_req(req_b), .imem_addr(addr_b),
    .imem_rvalid(rvalid_b), .imem_rdata(rdata_b),
    .stall(stall_b), .redirect(redir_b), .redirect_pc(rpc_b),
    .if_valid(valid_b), .if_instr(instr_b), .if_opcode(opc_b), .if_cond(cond_b),
    .if_pc(pc_b), .if_pc_plus1(p1_b), .dbg_state(st_b)
  );

  // ---------------- instruction memory models -----------------------------
  function automatic logic [15:0] mem_word(input logic [15:0] a);
    case (a)
      16'h0000: mem_word = 16'h0123;
      16'h0001: mem_word = 16'h1456;
      16'hFFFF: mem_word = 16'hC5AA;
      default:  mem_word = 16'h2000 | (a & 16'h0FFF);
    endcase
  endfunction

  int          lat = 1;
  int          cnt_a = 0;
  logic [15:0] pend_a = '0;

  initial begin
    rvalid_a = 1'b0;
    rdata_a  = '0;
    rvalid_b = 1'b0;
    rdata_b  = '0;
  end

  always @(posedge clk) begin
    if (rst) begin
      rvalid_a <= 1'b0;
      cnt_a    <= 0;
    end else begin
      rvalid_a <= 1'b0;
      if (cnt_a == 1) begin
        rvalid_a <= 1'b1;
        rdata_a  <= mem_word(pend_a);
      end
      if (cnt_a > 0) cnt_a <= cnt_a - 1;
      if (req_a) begin
        if (lat <= 1) begin
          rvalid_a <= 1'b1;
          rdata_a  <= mem_word(addr_a);
        end else begin
          cnt_a  <= lat - 1;
          pend_a <= addr_a;
        end
      end
    end
  end

  always @(posedge clk) begin
    rvalid_b <= !rst && req_b;
    rdata_b  <= mem_word(addr_b);
  end

  // ---------------- scoreboard ---------------------------------------------
  int checks   = 0;
  int failures = 0;

  task automatic chk(input string nm, input int row, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s row=%0d actual=%h required=%h", nm, row, act, exp);
    end
  endtask

  // ---------------- vector table -------------------------------------------
  typedef struct {
    logic        stall;
    logic        redir;
    logic [15:0] rpc;
    int          lat;
    logic        req;
    logic [15:0] addr;
    logic        valid;
    logic [15:0] pc;
    logic [15:0] instr;
    logic [1:0]  st;
  } vec_t;

  vec_t v[64];
  int   nvec = 0;

  task automatic row(input logic s, input logic r, input logic [15:0] rp, input int l,
                     input logic q, input logic [15:0] a, input logic vl,
                     input logic [15:0] p, input logic [15:0] ins, input logic [1:0] st);
    v[nvec] = '{s, r, rp, l, q, a, vl, p, ins, st};
    nvec++;
  endtask

  task automatic check_b(input int i, input logic [15:0] e_addr, input logic [15:0] e_pc,
                         input logic [15:0] e_instr);
    logic [15:0] e_p1;
    e_p1 = e_pc + 16'h0001;
    chk("b_req", i, 32'(req_b), 32'(1'b1));
    chk("b_addr", i, 32'(addr_b), 32'(e_addr));
    chk("b_valid", i, 32'(valid_b), 32'(1'b1));
    chk("b_pc", i, 32'(pc_b), 32'(e_pc));
    chk("b_instr", i, 32'(instr_b), 32'(e_instr));
    chk("b_opcode", i, 32'(opc_b), 32'(e_instr[15:12]));
    chk("b_cond", i, 32'(cond_b), 32'(e_instr[11:9]));
    chk("b_pc_plus1", i, 32'(p1_b), 32'(e_p1));
  endtask

  initial begin
    #200000;
    $display("FAIL timeout no_finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] e_p1;
    rst = 1'b1;
    stall_a = 0; redir_a = 0; rpc_a = '0;
    stall_b = 0; redir_b = 0; rpc_b = '0;

    // cycle-by-cycle: stall redir rpc lat | req addr valid pc instr state
    // straight-line fetch, 1-cycle memory
    row(0,0,16'h0,1, 1,16'h0000, 0,16'h0,16'h0,    ISSUE);  // 0
    row(0,0,16'h0,1, 0,16'h0,    0,16'h0,16'h0,    WAIT);
    row(0,0,16'h0,1, 1,16'h0001, 1,16'h0000,16'h0123, ISSUE);
    row(0,0,16'h0,1, 0,16'h0,    0,16'h0,16'h0,    WAIT);
    row(0,0,16'h0,1, 1,16'h0002, 1,16'h0001,16'h1456, ISSUE);
    row(0,0,16'h0,1, 0,16'h0,    0,16'h0,16'h0,    WAIT);   // 5
    // stall 5 cycles while pc 2 is presented; pc 3 lands in hold
    row(1,0,16'h0,1, 1,16'h0003, 1,16'h0002,16'h2002, ISSUE);
    row(1,0,16'h0,1, 0,16'h0,    1,16'h0002,16'h2002, WAIT);
    row(1,0,16'h0,1, 0,16'h0,    1,16'h0002,16'h2002, HOLD);
    row(1,0,16'h0,1, 0,16'h0,    1,16'h0002,16'h2002, HOLD);
    row(1,0,16'h0,1, 0,16'h0,    1,16'h0002,16'h2002, HOLD); // 10
    row(0,0,16'h0,1, 0,16'h0,    1,16'h0002,16'h2002, HOLD);
    row(0,0,16'h0,1, 1,16'h0004, 1,16'h0003,16'h2003, ISSUE);
    row(0,0,16'h0,1, 0,16'h0,    0,16'h0,16'h0,    WAIT);
    // 3-cycle memory, redirect one cycle after the request for 0005
    row(0,0,16'h0,3, 1,16'h0005, 1,16'h0004,16'h2004, ISSUE);
    row(0,1,16'h0040,3, 0,16'h0, 0,16'h0,16'h0,    WAIT);   // 15
    row(0,0,16'h0,3, 0,16'h0,    0,16'h0,16'h0,    WAIT);
    row(0,0,16'h0,3, 0,16'h0,    0,16'h0,16'h0,    WAIT);
    row(0,0,16'h0,1, 1,16'h0040, 0,16'h0,16'h0,    ISSUE);
    row(0,0,16'h0,1, 0,16'h0,    0,16'h0,16'h0,    WAIT);
    // redirect during stall with hold full
    row(1,0,16'h0,1, 1,16'h0041, 1,16'h0040,16'h2040, ISSUE); // 20
    row(1,0,16'h0,1, 0,16'h0,    1,16'h0040,16'h2040, WAIT);
    row(1,1,16'h0100,1, 0,16'h0, 1,16'h0040,16'h2040, HOLD);
    row(0,0,16'h0,1, 1,16'h0100, 0,16'h0,16'h0,    ISSUE);
    row(0,0,16'h0,1, 0,16'h0,    0,16'h0,16'h0,    WAIT);
    row(0,0,16'h0,1, 1,16'h0101, 1,16'h0100,16'h2100, ISSUE); // 25
    // redirect coinciding with rvalid, then redirect in ISSUE
    row(0,1,16'h0200,1, 0,16'h0, 0,16'h0,16'h0,    WAIT);
    row(0,1,16'h0300,1, 1,16'h0200, 0,16'h0,16'h0, ISSUE);
    row(0,0,16'h0,1, 0,16'h0,    0,16'h0,16'h0,    WAIT);
    row(0,0,16'h0,1, 1,16'h0300, 0,16'h0,16'h0,    ISSUE);
    row(0,0,16'h0,1, 0,16'h0,    0,16'h0,16'h0,    WAIT);   // 30
    row(0,0,16'h0,1, 1,16'h0301, 1,16'h0300,16'h2300, ISSUE);

    // reset: two edges with rst high, outputs must be cleared
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req_a", -1, 32'(req_a), 32'(1'b0));
    chk("rst_valid_a", -1, 32'(valid_a), 32'(1'b0));
    chk("rst_instr_a", -1, 32'(instr_a), 32'h0);
    chk("rst_pc_a", -1, 32'(pc_a), 32'h0);
    chk("rst_pc_plus1_a", -1, 32'(p1_a), 32'h0);
    chk("rst_state_a", -1, 32'(st_a), 32'(ISSUE));
    chk("rst_req_b", -1, 32'(req_b), 32'(1'b0));
    chk("rst_valid_b", -1, 32'(valid_b), 32'(1'b0));
    rst = 1'b0;

    for (int i = 0; i < nvec; i++) begin
      stall_a = v[i].stall;
      redir_a = v[i].redir;
      rpc_a   = v[i].rpc;
      lat     = v[i].lat;
      #1;
      chk("state", i, 32'(st_a), 32'(v[i].st));
      chk("imem_req", i, 32'(req_a), 32'(v[i].req));
      if (v[i].req) chk("imem_addr", i, 32'(addr_a), 32'(v[i].addr));
      chk("if_valid", i, 32'(valid_a), 32'(v[i].valid));
      if (v[i].valid) begin
        e_p1 = v[i].pc + 16'h0001;
        chk("if_pc", i, 32'(pc_a), 32'(v[i].pc));
        chk("if_instr", i, 32'(instr_a), 32'(v[i].instr));
        chk("if_opcode", i, 32'(opc_a), 32'(v[i].instr[15:12]));
        chk("if_cond", i, 32'(cond_a), 32'(v[i].instr[11:9]));
        chk("if_pc_plus1", i, 32'(p1_a), 32'(e_p1));
      end
      // wrap instance: first fetch FFFF, then 0000 after the wrap
      if (i == 0) begin
        chk("b_req0", i, 32'(req_b), 32'(1'b1));
        chk("b_addr0", i, 32'(addr_b), 32'hFFFF);
      end
      if (i == 2) check_b(i, 16'h0000, 16'hFFFF, 16'hC5AA);
      if (i == 4) check_b(i, 16'h0001, 16'h0000, 16'h0123);
      @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Producer side of the decode interface: fetches 16-bit instructions and presents `OpCode`/`Cond` fields, PC and PC+1 to the control/decode logic.
- Owns the program counter.
- Talks to instruction memory with a single-outstanding request/response handshake.
- Accepts stall and redirect (taken branch, JAL, JR target) from the control path, and buffers one response so memory is never back-pressured.

Parameters:
- ADDR_W, 16, PC and instruction-memory address width.
- INSTR_W, 16, instruction width; opcode [15:12], cond [11:9].
- RESET_PC, 16'h0000, first fetch address after reset.

Ports:
- clk  in  1  single clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- imem_req  out  1  fetch request; memory accepts it in the same cycle.
- imem_addr  out  ADDR_W  fetch address, valid when imem_req=1.
- imem_rvalid  in  1  response strobe, ≥1 cycle after accepted request.
- imem_rdata  in  INSTR_W  instruction, valid with imem_rvalid.
- stall  in  1  decode not accepting this cycle.
- redirect  in  1  control-flow change; overrides stall.
- redirect_pc  in  ADDR_W  new fetch address, valid with redirect.
- if_valid  out  1  instruction presented to decode.
- if_instr  out  INSTR_W  full instruction word.
- if_opcode  out  4  if_instr[15:12].
- if_cond  out  3  if_instr[11:9].
- if_pc  out  ADDR_W  address of if_instr.
- if_pc_plus1  out  ADDR_W  if_pc+1, mod 2^ADDR_W, used as JAL link.

Behaviour:
- Reset (rst=1 at an edge):
  - pc=RESET_PC, state=ISSUE, kill=0, hold empty.
  - if_valid=0; if_instr, if_pc, if_pc_plus1 = 0.
  - imem_req=0 while rst is high.
  - Instruction memory shares rst and drops any outstanding response.
- Output register: consumed when if_valid && !stall. Field outputs are combinational slices of if_instr.
- FSM:
  - ISSUE: imem_req=1, imem_addr=pc; next state WAIT.
  - WAIT: imem_req=0; waits for imem_rvalid.
    - If kill=1: discard the data, clear kill, go to ISSUE.
    - Else if output is empty or consumed this cycle: load output (instr, pc, pc+1), pc<=pc+1, go to ISSUE.
    - Else: write hold (instr, pc), pc<=pc+1, go to HOLD.
  - HOLD: no request issued.
    - When the output is consumed: hold moves to output next edge, hold cleared, go to ISSUE.
- Throughput: with 1-cycle memory, one instruction per 2 cycles (ISSUE, WAIT). Each additional memory latency cycle adds one.
- Redirect (highest priority after rst):
  - pc<=redirect_pc; if_valid<=0; hold cleared.
  - If state is WAIT and imem_rvalid=0 that cycle: kill<=1, stay in WAIT.
  - If state is ISSUE: the request issued this cycle is killed (kill<=1, go to WAIT).
  - Otherwise go to ISSUE.
  - Same-cycle rvalid and redirect: the response is discarded, go to ISSUE.
- PC arithmetic: unsigned, wraps 16'hFFFF→16'h0000; no overflow flag.
- Stall never drops or duplicates an instruction. Outputs hold stable while if_valid && stall.
- At most one request outstanding and one instruction buffered; hold is never written while full.

Decomposition:
- Shared package cpu_pkg holds:
  - opcode constants OP_ADD..OP_EXEC (4'h0..4'hF);
  - field positions OPC_MSB=15, OPC_LSB=12, COND_MSB=11, COND_LSB=9;
  - fetch state encoding ISSUE/WAIT/HOLD;
  - branch-cond constants (EQ=3'b000 .. TRUE=3'b111).
- One natural sub-module: if_hold_reg, a one-entry instruction+pc buffer with write/read/clear. The FSM and PC stay in the top module.

Test Plan:
- Reset: rst high 2 cycles, then low → all outputs 0 during reset; first cycle after release imem_req=1, imem_addr=16'h0000.
- Straight-line fetch, 1-cycle memory, mem[0]=16'h0123, mem[1]=16'h1456:
  - if_valid pulses for pc 0 then pc 1;
  - if_opcode 4'h0 then 4'h1;
  - if_pc_plus1 16'h0001 then 16'h0002;
  - imem_req every other cycle.
- Stall: stall=1 for 5 cycles while pc 2 is presented:
  - pc 3's response goes to hold; imem_req stays 0 in HOLD; if_instr stays stable.
  - stall drops → pc 3 appears next cycle; fetch of pc 4 follows.
- Redirect in WAIT: 3-cycle memory, redirect=1, redirect_pc=16'h0040 one cycle after the request for 16'h0005:
  - stale response discarded, if_valid stays 0;
  - next imem_addr=16'h0040; first if_pc is 16'h0040.
- Redirect during stall with hold full: redirect_pc=16'h0100 → if_valid=0 and hold empty next cycle; next fetch is 16'h0100.
- Wrap and fields: RESET_PC=16'hFFFF, mem[FFFF]=16'hC5AA:
  - if_opcode=4'hC, if_cond=3'b010, if_pc_plus1=16'h0000;
  - second imem_addr=16'h0000.
